// File: rtl/apb_controller.sv
// apb_controller
//   APB master state machine of the AHB-to-APB bridge. It takes a qualified
//   AHB address-phase transfer, runs the APB SETUP/ACCESS sequence and
//   stretches the AHB data phase through Hreadyout until the access completes.
//
// Ports
//   Hclk, Hreset        clock (rising edge), asynchronous active-high reset
//   valid               qualified AHB transfer presented in the address phase
//   Hwrite, Haddr       direction and address of the address-phase transfer
//   Hwdata              AHB write data, valid in the data phase
//   tempselx            one-hot peripheral select decoded from Haddr
//   Pready              APB completer ready
//   Pselx, Penable,
//   Pwrite, Paddr,
//   Pwdata              registered APB master outputs
//   Hreadyout           AHB ready, combinational from state and Pready
module apb_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [NSEL-1:0]   tempselx,
  input  logic              Pready,
  output logic [NSEL-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSETUP  = 3'd1,
    RACCESS = 3'd2,
    WWAIT   = 3'd3,
    WSETUP  = 3'd4,
    WACCESS = 3'd5
  } state_t;

  state_t          state;
  logic [NSEL-1:0] sel_q;    // write select parked until write data arrives
  logic            in_access;
  logic            accept;

  assign in_access = (state == RACCESS) || (state == WACCESS);

  // Ready is only high in IDLE or at the completing ACCESS cycle, so a
  // transfer is taken exactly when the AHB side sees Hreadyout=1.
  assign accept = valid && ((state == IDLE) || (in_access && Pready));

  always_comb begin
    Hreadyout = 1'b0;
    case (state)
      IDLE:             Hreadyout = 1'b1;
      RACCESS, WACCESS: Hreadyout = Pready;
      default:          Hreadyout = 1'b0;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state   <= IDLE;
      sel_q   <= '0;
      Pselx   <= '0;
      Penable <= 1'b0;
      Pwrite  <= 1'b0;
      Paddr   <= '0;
      Pwdata  <= '0;
    end else if (accept) begin
      // New transfer: from IDLE or back-to-back off a completing access.
      Paddr   <= Haddr;
      Penable <= 1'b0;
      Pwrite  <= Hwrite;
      if (Hwrite) begin
        // Write data only shows up in the AHB data phase, so hold off
        // the SETUP phase one cycle (WWAIT) and keep the select aside.
        state <= WWAIT;
        sel_q <= tempselx;
        Pselx <= '0;
      end else begin
        state <= RSETUP;
        Pselx <= tempselx;
      end
    end else begin
      case (state)
        RSETUP: begin
          state   <= RACCESS;
          Penable <= 1'b1;
        end
        WWAIT: begin
          state  <= WSETUP;
          Pwdata <= Hwdata;
          Pselx  <= sel_q;
        end
        WSETUP: begin
          state   <= WACCESS;
          Penable <= 1'b1;
        end
        RACCESS, WACCESS: begin
          // Pready low: wait state, everything holds.
          if (Pready) begin
            state   <= IDLE;
            Pselx   <= '0;
            Penable <= 1'b0;
          end
        end
        IDLE: begin
          Pselx   <= '0;
          Penable <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Pselx   <= '0;
          Penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
module tb_apb_controller;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        valid, Hwrite, Pready;
  logic [31:0] Haddr, Hwdata;
  logic [2:0]  tempselx;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite, Hreadyout;
  logic [31:0] Paddr, Pwdata;

  int checks = 0;
  int errors = 0;

  always #5 Hclk = ~Hclk;

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite),
    .Haddr(Haddr), .Hwdata(Hwdata), .tempselx(tempselx), .Pready(Pready),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .Pwdata(Pwdata), .Hreadyout(Hreadyout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One row = inputs driven for a cycle and the outputs expected in that
  // same cycle (before the next rising edge).
  typedef struct {
    logic        v, w;
    logic [31:0] a, d;
    logic [2:0]  s;
    logic        pr;
    logic [2:0]  e_sel;
    logic        e_en, e_wr;
    logic [31:0] e_addr, e_wd;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[13];

  // Transaction-level reference: a pending transfer with a count of
  // stall cycles left before its ACCESS phase.
  logic        m_pend;
  int          m_pre;
  logic [2:0]  m_sel;
  logic        m_pwrite;
  logic [31:0] m_paddr, m_pwdata;

  function automatic logic m_ready(input logic pr);
    if (!m_pend) return 1'b1;
    return (m_pre == 0) ? pr : 1'b0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pre = 0; m_sel = '0;
    m_pwrite = 0; m_paddr = '0; m_pwdata = '0;
  endtask

  task automatic model_step();
    logic acc;
    acc = valid && m_ready(Pready);
    if (m_pend && m_pre == 2) m_pwdata = Hwdata;
    if (acc) begin
      m_pend = 1; m_sel = tempselx; m_pwrite = Hwrite; m_paddr = Haddr;
      m_pre = Hwrite ? 2 : 1;
    end else if (m_pend) begin
      if (m_pre > 0) m_pre--;
      else if (Pready) m_pend = 0;
    end
  endtask

  task automatic model_check();
    check("rnd_pselx",  {29'd0, Pselx}, {29'd0, (m_pend && m_pre < 2) ? m_sel : 3'b000});
    check("rnd_penable", {31'd0, Penable}, {31'd0, m_pend && m_pre == 0});
    check("rnd_pwrite", {31'd0, Pwrite}, {31'd0, m_pwrite});
    check("rnd_paddr",  Paddr, m_paddr);
    check("rnd_pwdata", Pwdata, m_pwdata);
    check("rnd_hready", {31'd0, Hreadyout}, {31'd0, m_ready(Pready)});
  endtask

  task automatic do_reset();
    Hreset = 1'b1;
    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;
  endtask

  initial begin
    Hreset = 1'b1; valid = 0; Hwrite = 0; Haddr = '0; Hwdata = '0;
    tempselx = '0; Pready = 1'b1;

    //        v  w  addr          wdata         sel     pr  e_sel   en wr e_addr        e_wd          rdy
    tbl[0]  = '{1, 0, 32'h8000_0010, 32'h0,         3'b001, 1, 3'b000, 0, 0, 32'h0,         32'h0,         1};
    tbl[1]  = '{0, 0, 32'h0,         32'h0,         3'b000, 1, 3'b001, 0, 0, 32'h8000_0010, 32'h0,         0};
    tbl[2]  = '{0, 0, 32'h0,         32'h0,         3'b000, 1, 3'b001, 1, 0, 32'h8000_0010, 32'h0,         1};
    tbl[3]  = '{1, 1, 32'h8400_0004, 32'h0,         3'b010, 1, 3'b000, 0, 0, 32'h8000_0010, 32'h0,         1};
    tbl[4]  = '{0, 0, 32'h0,         32'hDEAD_BEEF, 3'b000, 1, 3'b000, 0, 1, 32'h8400_0004, 32'h0,         0};
    tbl[5]  = '{0, 0, 32'h0,         32'h0,         3'b000, 1, 3'b010, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 0};
    tbl[6]  = '{1, 0, 32'h8800_0000, 32'h0,         3'b100, 1, 3'b010, 1, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1};
    tbl[7]  = '{1, 1, 32'h9000_0000, 32'h0,         3'b001, 0, 3'b100, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF, 0};
    tbl[8]  = '{0, 0, 32'h0,         32'h0,         3'b000, 0, 3'b100, 1, 0, 32'h8800_0000, 32'hDEAD_BEEF, 0};
    tbl[9]  = '{0, 0, 32'h0,         32'h0,         3'b000, 0, 3'b100, 1, 0, 32'h8800_0000, 32'hDEAD_BEEF, 0};
    tbl[10] = '{0, 0, 32'h0,         32'h0,         3'b000, 1, 3'b100, 1, 0, 32'h8800_0000, 32'hDEAD_BEEF, 1};
    tbl[11] = '{0, 0, 32'h9000_0000, 32'h0,         3'b001, 1, 3'b000, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF, 1};
    tbl[12] = '{0, 1, 32'h9000_0000, 32'h0,         3'b001, 1, 3'b000, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF, 1};

    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;
    #1;
    check("rst_pselx",  {29'd0, Pselx}, 32'd0);
    check("rst_penable", {31'd0, Penable}, 32'd0);
    check("rst_paddr",  Paddr, 32'd0);
    check("rst_pwdata", Pwdata, 32'd0);
    check("rst_hready", {31'd0, Hreadyout}, 32'd1);

    // Directed table: read, write, back-to-back, wait states, ignored transfers.
    for (int i = 0; i < 13; i++) begin
      @(negedge Hclk);
      valid = tbl[i].v; Hwrite = tbl[i].w; Haddr = tbl[i].a; Hwdata = tbl[i].d;
      tempselx = tbl[i].s; Pready = tbl[i].pr;
      #1;
      check($sformatf("vec%0d_pselx", i),  {29'd0, Pselx}, {29'd0, tbl[i].e_sel});
      check($sformatf("vec%0d_penable", i), {31'd0, Penable}, {31'd0, tbl[i].e_en});
      check($sformatf("vec%0d_pwrite", i), {31'd0, Pwrite}, {31'd0, tbl[i].e_wr});
      check($sformatf("vec%0d_paddr", i),  Paddr, tbl[i].e_addr);
      check($sformatf("vec%0d_pwdata", i), Pwdata, tbl[i].e_wd);
      check($sformatf("vec%0d_hready", i), {31'd0, Hreadyout}, {31'd0, tbl[i].e_rdy});
    end

    // Reset asserted asynchronously mid-WACCESS while stalled.
    @(negedge Hclk);
    valid = 1; Hwrite = 1; Haddr = 32'h8400_0008; tempselx = 3'b010; Pready = 0;
    @(negedge Hclk);
    valid = 0; Hwdata = 32'h1234_5678;
    repeat (2) @(negedge Hclk);
    #1;
    check("mid_penable", {31'd0, Penable}, 32'd1);
    check("mid_hready",  {31'd0, Hreadyout}, 32'd0);
    check("mid_pwdata",  Pwdata, 32'h1234_5678);
    #1 Hreset = 1'b1;
    #1;
    check("arst_pselx",  {29'd0, Pselx}, 32'd0);
    check("arst_penable", {31'd0, Penable}, 32'd0);
    check("arst_pwdata", Pwdata, 32'd0);
    check("arst_paddr",  Paddr, 32'd0);
    check("arst_hready", {31'd0, Hreadyout}, 32'd1);
    @(negedge Hclk);
    Hreset = 1'b0;

    // Randomized traffic against the reference model.
    Pready = 1;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge Hclk);
      valid    = ($urandom_range(0, 99) < 55);
      Hwrite   = $urandom_range(0, 1);
      Haddr    = $urandom;
      Hwdata   = $urandom;
      tempselx = 3'b001 << $urandom_range(0, 2);
      Pready   = ($urandom_range(0, 99) < 70);
      #1;
      model_check();
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
